// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: compares the incoming time of day against a stored
// alarm time, rings for RING_SECS second-events, and supports stop and set.
// Optional feature macro: ALARM_SNOOZE_EN. When defined, up to MAX_SNOOZE
// snoozes of SNOOZE_SECS second-events each are allowed per alarm occurrence.
// When undefined, the snooze input is ignored and snooze_cnt reads as 0.
module alarm_ctrl #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter int unsigned MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] hrs,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic       arm,
   input  logic       set_en,
   input  logic [4:0] set_hrs,
   input  logic [5:0] set_min,
   input  logic       snooze,
   input  logic       stop,
   output logic       ring,
   output logic [1:0] state,
   output logic [4:0] alm_hrs,
   output logic [5:0] alm_min,
   output logic [1:0] snooze_cnt
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StRinging = 2'd2,
      StSnooze  = 2'd3
   } state_e;

   // One shared counter serves both the ring timeout and the snooze period.
   localparam int unsigned CntMax = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
   localparam logic [CntW-1:0] RingLast = CntW'(RING_SECS - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] ring_cnt_q, ring_cnt_d;
   logic [5:0]      sec_q;
   logic [4:0]      alm_hrs_q;
   logic [5:0]      alm_min_q;
   logic            sec_evt;
   logic            match;
   logic            set_ok;

   assign sec_evt = (sec != sec_q);
   assign match   = sec_evt && (sec == 6'd0) && (hrs == alm_hrs_q) && (min == alm_min_q);
   assign set_ok  = set_en && (set_hrs <= 5'd23) && (set_min <= 6'd59);

`ifdef ALARM_SNOOZE_EN
   localparam logic [CntW-1:0] SnoozeLast = CntW'(SNOOZE_SECS - 1);

   logic [1:0] snooze_cnt_q, snooze_cnt_d;
`else
   // Snooze input and its limit have no effect in this build.
   logic unused_snooze;
   assign unused_snooze = snooze ^ (MAX_SNOOZE != 0);
`endif

   // Second-edge history and the stored alarm time (loaded only with a legal time)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_q     <= '0;
         alm_hrs_q <= '0;
         alm_min_q <= '0;
      end else begin
         sec_q <= sec;
         if (set_ok) begin
            alm_hrs_q <= set_hrs;
            alm_min_q <= set_min;
         end
      end
   end

   // FSM state and counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         ring_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   // Snooze usage counter for the current occurrence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snooze_cnt_q <= '0;
      end else begin
         snooze_cnt_q <= snooze_cnt_d;
      end
   end

   assign snooze_cnt = snooze_cnt_q;
`else
   assign snooze_cnt = 2'd0;
`endif

   // Next-state logic; arm=0 overrides everything, stop/set beat snooze, snooze beats timeout
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_d = snooze_cnt_q;
`endif
      if (!arm) begin
         state_d    = StIdle;
         ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
         snooze_cnt_d = '0;
`endif
      end else begin
         case (state_q)
            StIdle: state_d = StArmed;
            StArmed: begin
               if (match) begin
                  state_d    = StRinging;
                  ring_cnt_d = '0;
               end
            end
            StRinging: begin
               if (stop || set_ok) begin
                  state_d    = StArmed;
                  ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
                  snooze_cnt_d = '0;
               end else if (snooze && (32'(snooze_cnt_q) < MAX_SNOOZE)) begin
                  state_d      = StSnooze;
                  ring_cnt_d   = '0;
                  snooze_cnt_d = snooze_cnt_q + 2'd1;
`endif
               end else if (sec_evt) begin
                  if (ring_cnt_q == RingLast) begin
                     state_d    = StArmed;
                     ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
                     snooze_cnt_d = '0;
`endif
                  end else begin
                     ring_cnt_d = ring_cnt_q + CntW'(1);
                  end
               end
            end
            StSnooze: begin
`ifdef ALARM_SNOOZE_EN
               if (stop || set_ok) begin
                  state_d      = StArmed;
                  ring_cnt_d   = '0;
                  snooze_cnt_d = '0;
               end else if (sec_evt) begin
                  if (ring_cnt_q == SnoozeLast) begin
                     state_d    = StRinging;
                     ring_cnt_d = '0;
                  end else begin
                     ring_cnt_d = ring_cnt_q + CntW'(1);
                  end
               end
`else
               // Unreachable without snooze support; recover to ARMED.
               state_d    = StArmed;
               ring_cnt_d = '0;
`endif
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign ring    = (state_q == StRinging);
   assign state   = state_q;
   assign alm_hrs = alm_hrs_q;
   assign alm_min = alm_min_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios followed by random
// traffic, all checked against a countdown-style reference model.
module tb_alarm_ctrl;

   localparam int unsigned RING = 60;
   localparam int unsigned SNZ  = 300;
   localparam int unsigned MAXS = 3;
`ifdef ALARM_SNOOZE_EN
   localparam bit SnzEn = 1'b1;
`else
   localparam bit SnzEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] hrs = '0;
   logic [5:0] min = '0;
   logic [5:0] sec = '0;
   logic       arm = 1'b0;
   logic       set_en = 1'b0;
   logic [4:0] set_hrs = '0;
   logic [5:0] set_min = '0;
   logic       snooze = 1'b0;
   logic       stop = 1'b0;
   logic       ring;
   logic [1:0] state;
   logic [4:0] alm_hrs;
   logic [5:0] alm_min;
   logic [1:0] snooze_cnt;

   always #5 clk = ~clk;

   alarm_ctrl #(
      .RING_SECS  (RING),
      .SNOOZE_SECS(SNZ),
      .MAX_SNOOZE (MAXS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hrs       (hrs),
      .min       (min),
      .sec       (sec),
      .arm       (arm),
      .set_en    (set_en),
      .set_hrs   (set_hrs),
      .set_min   (set_min),
      .snooze    (snooze),
      .stop      (stop),
      .ring      (ring),
      .state     (state),
      .alm_hrs   (alm_hrs),
      .alm_min   (alm_min),
      .snooze_cnt(snooze_cnt)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: mode 0..3, events remaining in the current phase
   int m_st, m_left, m_snz, m_ah, m_am, m_prev;
   int cur_h, cur_m, cur_s;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_left = 0; m_snz = 0; m_ah = 0; m_am = 0; m_prev = 0;
   endtask

   task automatic model_edge();
      bit evt, mt, sok;
      int ns;
      evt = (int'(sec) != m_prev);
      mt  = evt && (int'(sec) == 0) && (int'(hrs) == m_ah) && (int'(min) == m_am);
      sok = set_en && (int'(set_hrs) <= 23) && (int'(set_min) <= 59);
      ns  = m_st;
      if (!arm) begin
         ns = 0; m_left = 0; m_snz = 0;
      end else begin
         case (m_st)
            0: ns = 1;
            1: if (mt) begin ns = 2; m_left = RING; end
            2: begin
               if (stop || sok) begin
                  ns = 1; m_snz = 0;
               end else if (SnzEn && snooze && m_snz < int'(MAXS)) begin
                  ns = 3; m_snz++; m_left = SNZ;
               end else if (evt) begin
                  m_left--;
                  if (m_left == 0) begin ns = 1; m_snz = 0; end
               end
            end
            default: begin
               if (stop || sok) begin
                  ns = 1; m_snz = 0;
               end else if (evt) begin
                  m_left--;
                  if (m_left == 0) begin ns = 2; m_left = RING; end
               end
            end
         endcase
      end
      if (sok) begin m_ah = int'(set_hrs); m_am = int'(set_min); end
      m_prev = int'(sec);
      m_st   = ns;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ring"}, int'(ring), (m_st == 2) ? 1 : 0);
      chk({tag, ".state"}, int'(state), m_st);
      chk({tag, ".alm_hrs"}, int'(alm_hrs), m_ah);
      chk({tag, ".alm_min"}, int'(alm_min), m_am);
      chk({tag, ".snooze_cnt"}, int'(snooze_cnt), m_snz);
   endtask

   // One clock edge; outputs sampled 1ns after it
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      if (!rst) model_reset();
      else model_edge();
      check_all(tag);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_h = h; cur_m = m; cur_s = s;
      hrs = 5'(h); min = 6'(m); sec = 6'(s);
   endtask

   task automatic adv_sec();
      int h, m, s;
      h = cur_h; m = cur_m; s = cur_s + 1;
      if (s == 60) begin s = 0; m++; end
      if (m == 60) begin m = 0; h++; end
      if (h == 24) h = 0;
      set_time(h, m, s);
   endtask

   task automatic ring_now(input int h, input int m);
      set_time(h, m, 59);
      tick("pre_alarm");
      set_time(h, m, 0);
      tick("alarm");
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1; tick("snooze"); snooze = 1'b0;
   endtask

   task automatic run_secs(input int n);
      for (int i = 0; i < n; i++) begin
         adv_sec();
         tick("secs");
      end
   endtask

   initial begin
      // Asynchronous reset with the time already at 07:30:00
      set_time(7, 30, 0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      arm = 1'b1;
      repeat (2) tick("in_reset");
      rst = 1'b1;
      repeat (4) tick("hold0730");
      chk("hold.ring", int'(ring), 0);
      chk("hold.state", int'(state), 1);

      // Set alarm 07:30 and reach it from 07:29:59
      set_en = 1'b1; set_hrs = 5'd7; set_min = 6'd30;
      tick("set0730");
      set_en = 1'b0;
      chk("set.alm_hrs", int'(alm_hrs), 7);
      chk("set.alm_min", int'(alm_min), 30);
      set_time(7, 29, 59);
      tick("t072959");
      chk("before.ring", int'(ring), 0);
      set_time(7, 30, 0);
      tick("t073000");
      chk("match.ring", int'(ring), 1);
      chk("match.state", int'(state), 2);

      // Auto-timeout after RING second-events
      run_secs(RING - 1);
      chk("to59.state", int'(state), 2);
      run_secs(1);
      chk("to60.state", int'(state), 1);
      chk("to60.ring", int'(ring), 0);

      // Out-of-range set is ignored
      set_en = 1'b1; set_hrs = 5'd24; set_min = 6'd10;
      tick("bad_set");
      set_en = 1'b0;
      chk("badset.alm_hrs", int'(alm_hrs), 7);
      chk("badset.alm_min", int'(alm_min), 30);

      // Stop and snooze together: stop wins
      ring_now(7, 30);
      chk("ring2.state", int'(state), 2);
      stop = 1'b1; snooze = 1'b1;
      tick("stop_snooze");
      stop = 1'b0; snooze = 1'b0;
      chk("stopsnz.state", int'(state), 1);
      chk("stopsnz.snooze_cnt", int'(snooze_cnt), 0);

      // Valid set while ringing re-arms with the new time
      ring_now(7, 30);
      set_en = 1'b1; set_hrs = 5'd8; set_min = 6'd15;
      tick("set_ringing");
      set_en = 1'b0;
      chk("setring.state", int'(state), 1);
      chk("setring.alm_hrs", int'(alm_hrs), 8);
      chk("setring.alm_min", int'(alm_min), 15);

      ring_now(8, 15);
      pulse_snooze();
`ifdef ALARM_SNOOZE_EN
      chk("snz1.state", int'(state), 3);
      chk("snz1.snooze_cnt", int'(snooze_cnt), 1);
      for (int k = 0; k < 2; k++) begin
         run_secs(SNZ - 1);
         chk("snz_wait.state", int'(state), 3);
         run_secs(1);
         chk("snz_rering.state", int'(state), 2);
         pulse_snooze();
         chk("snzn.state", int'(state), 3);
         chk("snzn.snooze_cnt", int'(snooze_cnt), k + 2);
      end
      run_secs(SNZ);
      chk("snz3.state", int'(state), 2);
      pulse_snooze();
      chk("snz4.state", int'(state), 2);
      chk("snz4.snooze_cnt", int'(snooze_cnt), 3);
      stop = 1'b1; tick("stop"); stop = 1'b0;
      chk("stop.snooze_cnt", int'(snooze_cnt), 0);
      ring_now(8, 15);
      pulse_snooze();
      chk("snz_again.state", int'(state), 3);
`else
      chk("nosnz.state", int'(state), 2);
      chk("nosnz.snooze_cnt", int'(snooze_cnt), 0);
`endif
      arm = 1'b0;
      tick("disarm");
      chk("disarm.state", int'(state), 0);
      arm = 1'b1;
      tick("rearm");
      chk("rearm.state", int'(state), 1);

      // Reset mid-ring drops ring without a clock edge
      ring_now(8, 15);
      chk("ring3.ring", int'(ring), 1);
      rst = 1'b0;
      #1;
      model_reset();
      chk("async.ring", int'(ring), 0);
      chk("async.state", int'(state), 0);
      chk("async.alm_hrs", int'(alm_hrs), 0);
      tick("rst_low");
      rst = 1'b1;
      tick("rst_rel");

      // Random traffic
      set_en = 1'b1;
      set_hrs = 5'($urandom_range(0, 23));
      set_min = 6'($urandom_range(0, 59));
      tick("rnd_set");
      set_en = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         arm     = ($urandom_range(0, 599) != 0);
         set_en  = ($urandom_range(0, 149) == 0);
         set_hrs = 5'($urandom_range(0, 31));
         set_min = 6'($urandom_range(0, 63));
         snooze  = ($urandom_range(0, 19) == 0);
         stop    = ($urandom_range(0, 119) == 0);
         case ($urandom_range(0, 9))
            0: set_time(m_ah, m_am, 0);
            1, 2, 3, 4, 5, 6: adv_sec();
            7: set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            default: ;
         endcase
         if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_all("rnd_async");
            tick("rnd_rst_low");
            rst = 1'b1;
         end
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60: second-events spent in RINGING before auto-timeout.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300: second-events spent in SNOOZE before re-ring.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3: snoozes allowed per alarm occurrence.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports hrs, min, sec: inputs of widths 5, 6 and 6, carrying the time from the upstream clock stage (0-23, 0-59, 0-59).
REQ-007 SHALL have port arm  input  1  level; 1 = alarm enabled.
REQ-008 SHALL have ports set_en, set_hrs and set_min: inputs of widths 1, 5 and 6; a set_en pulse loads the alarm time.
REQ-009 SHALL have ports snooze and stop: inputs, 1 bit each, single-cycle user pulses.
REQ-010 SHALL have port ring  output  1  alarm sounding.
REQ-011 SHALL have port state  output  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-012 SHALL have ports alm_hrs and alm_min: outputs of widths 5 and 6, read back from the stored alarm time.
REQ-013 SHALL have port snooze_cnt  output  2  snoozes used in the current occurrence.

Function
REQ-014 SHALL register sec into sec_q every cycle; sec_evt = (sec != sec_q), combinational.
REQ-015 SHALL define match = sec_evt && sec==0 && hrs==alm_hrs && min==alm_min.
REQ-016 SHALL load alm_hrs/alm_min on set_en only if set_hrs<=23 and set_min<=59; otherwise registers unchanged.
REQ-017 SHALL drive ring = (state==RINGING), decoded from the state register: high the cycle after match.
REQ-018 SHALL transition IDLE->ARMED when arm=1, and any state->IDLE when arm=0, overriding all other inputs; entering IDLE clears snooze_cnt and ring_cnt.
REQ-019 SHALL transition ARMED->RINGING on match, clearing ring_cnt.
REQ-020 SHALL, in RINGING, increment ring_cnt per sec_evt, and transition to ARMED when ring_cnt reaches RING_SECS-1 on a sec_evt (timeout), clearing snooze_cnt.
REQ-021 SHALL transition RINGING->ARMED on stop, clearing snooze_cnt.
REQ-022 SHALL transition RINGING->SNOOZE on snooze when snooze_cnt<MAX_SNOOZE, incrementing snooze_cnt and clearing ring_cnt; at snooze_cnt==MAX_SNOOZE, snooze is ignored.
REQ-023 SHALL, in SNOOZE, count sec_evt in ring_cnt and transition to RINGING after SNOOZE_SECS events, clearing ring_cnt.
REQ-024 SHALL transition SNOOZE->ARMED on stop, clearing snooze_cnt.
REQ-025 SHALL, on stop and snooze in the same cycle, act on stop only.
REQ-026 SHALL, on a valid set_en while in RINGING or SNOOZE, load the new time and go to ARMED with snooze_cnt cleared; in IDLE or ARMED, the state is unchanged.
REQ-027 SHALL ignore match in RINGING and SNOOZE; ring_cnt SHALL be wide enough for max(RING_SECS, SNOOZE_SECS) without wrap.

Reset
REQ-028 SHALL, while rst=0, asynchronously force state=IDLE, ring=0, snooze_cnt=0, ring_cnt=0, sec_q=0, alm_hrs=0 and alm_min=0.
REQ-029 SHALL evaluate arm on the first clk edge after rst deasserts; a reset mid-RINGING drops ring immediately.

Configuration
REQ-030 SHALL, with ALARM_SNOOZE_EN defined, implement snooze per REQ-022/023.
REQ-031 SHALL, without ALARM_SNOOZE_EN, ignore the snooze input, make SNOOZE unreachable, tie snooze_cnt to 0, and omit the snooze counting logic.

Verification
REQ-032 SHALL cover: set 07:30, arm=1, drive time 07:29:59->07:30:00 -> ring=1 and state=2 on the next cycle; ring=0 before that.
REQ-033 SHALL cover: ringing, no input, 60 sec changes -> state=1 and ring=0 after the 60th sec_evt.
REQ-034 SHALL cover (ALARM_SNOOZE_EN): ringing, snooze pulse -> state=3 and snooze_cnt=1; after 300 sec_evt, state=2; a 4th snooze is ignored with snooze_cnt=3.
REQ-035 SHALL cover: stop and snooze in the same cycle while ringing -> state=1, snooze_cnt=0; a set_en with set_hrs=24 leaves alm_hrs unchanged.
REQ-036 SHALL cover: rst=0 asserted mid-RINGING -> ring=0 without a clk edge; arm=0 while SNOOZE -> state=0 next cycle.
REQ-037 SHALL cover: time held at 07:30:00 across reset with alarm 00:00 -> no match, ring stays 0.
